// File: rtl/ctrl_seq_unit_pkg.sv
// rtl/ctrl_seq_unit_pkg.sv - shared modes, opcodes, EXE commands, state enum and decode helper
package ctrl_pkg;

    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_TST = 4'b1000;

    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    typedef enum logic {IDLE, XFER} seq_state_t;

    typedef struct packed {
        logic [3:0] exe_cmd;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       wb_en;
        logic       b;
        logic       s_out;
    } ctrl_t;

    // Single-op decode of mode/op_code/S into the stage controls.
    function automatic ctrl_t decode(input logic [1:0] mode, input logic [3:0] op, input logic s);
        ctrl_t c;
        logic  is_test;
        c       = '0;
        is_test = (op == OP_CMP) || (op == OP_TST);
        if (mode == MODE_DP || mode == MODE_MEM) begin
            case (op)
                OP_MOV:  c.exe_cmd = EXE_MOV;
                OP_MVN:  c.exe_cmd = EXE_MVN;
                OP_ADD:  c.exe_cmd = EXE_ADD;
                OP_ADC:  c.exe_cmd = EXE_ADC;
                OP_SUB:  c.exe_cmd = EXE_SUB;
                OP_SBC:  c.exe_cmd = EXE_SBC;
                OP_AND:  c.exe_cmd = EXE_AND;
                OP_ORR:  c.exe_cmd = EXE_ORR;
                OP_EOR:  c.exe_cmd = EXE_EOR;
                OP_CMP:  c.exe_cmd = EXE_SUB;
                OP_TST:  c.exe_cmd = EXE_AND;
                default: c.exe_cmd = EXE_NOP;
            endcase
        end
        if (mode == MODE_MEM || mode == MODE_BR)
            c.s_out = 1'b0;
        else if (is_test)
            c.s_out = 1'b1;
        else
            c.s_out = s;
        c.mem_r_en = (mode == MODE_MEM) & s;
        c.mem_w_en = (mode == MODE_MEM) & ~s;
        c.b        = (mode == MODE_BR);
        if (mode == MODE_BR)
            c.wb_en = 1'b0;
        else if (mode == MODE_MEM && !s)
            c.wb_en = 1'b0;
        else if (mode == MODE_DP && is_test)
            c.wb_en = 1'b0;
        else
            c.wb_en = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/ctrl_seq_unit_if.sv
// rtl/ctrl_seq_unit_if.sv - ID-side inputs and issued micro-op outputs of the control sequencer
interface ctrl_seq_unit_if #(
    parameter int NREG  = 16,
    parameter int IDX_W = $clog2(NREG),
    parameter int OFS_W = $clog2(NREG) + 2
);
    logic             valid_i;
    logic             stall_i;
    logic             flush_i;
    logic [1:0]       mode;
    logic [3:0]       op_code;
    logic             s;
    logic             multi_i;
    logic [NREG-1:0]  reg_list_i;

    logic             valid_o;
    logic [3:0]       exe_cmd;
    logic             mem_r_en;
    logic             mem_w_en;
    logic             wb_en;
    logic             b;
    logic             s_out;
    logic [IDX_W-1:0] xfer_reg;
    logic [OFS_W-1:0] xfer_ofs;
    logic             last_o;
    logic             busy_o;

    modport master (
        output valid_i, stall_i, flush_i, mode, op_code, s, multi_i, reg_list_i,
        input  valid_o, exe_cmd, mem_r_en, mem_w_en, wb_en, b, s_out,
               xfer_reg, xfer_ofs, last_o, busy_o
    );

    modport slave (
        input  valid_i, stall_i, flush_i, mode, op_code, s, multi_i, reg_list_i,
        output valid_o, exe_cmd, mem_r_en, mem_w_en, wb_en, b, s_out,
               xfer_reg, xfer_ofs, last_o, busy_o
    );
endinterface

// File: rtl/ctrl_seq_unit_lowest_set_enc.sv
// rtl/ctrl_seq_unit_lowest_set_enc.sv - index of the lowest set bit plus an any-set flag
module lowest_set_enc #(
    parameter int NREG  = 16,
    parameter int IDX_W = $clog2(NREG)
) (
    input  logic [NREG-1:0]  vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (vec[i])
                idx = IDX_W'(i);
        end
        any = |vec;
    end

endmodule

// File: rtl/ctrl_seq_unit.sv
// rtl/ctrl_seq_unit.sv - registered decode control with block-transfer micro-op sequencer
module ctrl_seq_unit
    import ctrl_pkg::*;
#(
    parameter int NREG  = 16,
    parameter int IDX_W = $clog2(NREG),
    parameter int OFS_W = $clog2(NREG) + 2
) (
    input  logic           clk,
    input  logic           rst,
    ctrl_seq_unit_if.slave bus
);

    seq_state_t       state;
    logic [NREG-1:0]  mask;
    logic [IDX_W-1:0] count;
    logic             xfer_load;

    logic [IDX_W-1:0] in_idx;
    logic             in_any;
    logic [IDX_W-1:0] rem_idx;
    logic             rem_any;
    logic [NREG-1:0]  in_rest;
    logic [NREG-1:0]  rem_rest;
    logic             is_block;
    ctrl_t            dec;

    lowest_set_enc #(.NREG(NREG), .IDX_W(IDX_W)) u_enc_in (
        .vec (bus.reg_list_i),
        .idx (in_idx),
        .any (in_any)
    );

    lowest_set_enc #(.NREG(NREG), .IDX_W(IDX_W)) u_enc_rem (
        .vec (mask),
        .idx (rem_idx),
        .any (rem_any)
    );

    assign in_rest  = bus.reg_list_i & ~(NREG'(1) << in_idx);
    assign rem_rest = mask & ~(NREG'(1) << rem_idx);
    assign is_block = (bus.mode == MODE_MEM) && bus.multi_i;
    assign dec      = decode(bus.mode, bus.op_code, bus.s);
    assign bus.busy_o = (state == XFER);

    // Sequencer state and registered stage controls; flush beats stall, stall freezes everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            mask         <= '0;
            count        <= '0;
            xfer_load    <= 1'b0;
            bus.valid_o  <= 1'b0;
            bus.exe_cmd  <= EXE_NOP;
            bus.mem_r_en <= 1'b0;
            bus.mem_w_en <= 1'b0;
            bus.wb_en    <= 1'b0;
            bus.b        <= 1'b0;
            bus.s_out    <= 1'b0;
            bus.xfer_reg <= '0;
            bus.xfer_ofs <= '0;
            bus.last_o   <= 1'b0;
        end else if (bus.flush_i) begin
            state        <= IDLE;
            mask         <= '0;
            count        <= '0;
            xfer_load    <= 1'b0;
            bus.valid_o  <= 1'b0;
            bus.exe_cmd  <= EXE_NOP;
            bus.mem_r_en <= 1'b0;
            bus.mem_w_en <= 1'b0;
            bus.wb_en    <= 1'b0;
            bus.b        <= 1'b0;
            bus.s_out    <= 1'b0;
            bus.xfer_reg <= '0;
            bus.xfer_ofs <= '0;
            bus.last_o   <= 1'b0;
        end else if (!bus.stall_i) begin
            // Bubble unless one of the branches below issues something.
            bus.valid_o  <= 1'b0;
            bus.exe_cmd  <= EXE_NOP;
            bus.mem_r_en <= 1'b0;
            bus.mem_w_en <= 1'b0;
            bus.wb_en    <= 1'b0;
            bus.b        <= 1'b0;
            bus.s_out    <= 1'b0;
            bus.xfer_reg <= '0;
            bus.xfer_ofs <= '0;
            bus.last_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.valid_i && !is_block) begin
                        bus.valid_o  <= 1'b1;
                        bus.exe_cmd  <= dec.exe_cmd;
                        bus.mem_r_en <= dec.mem_r_en;
                        bus.mem_w_en <= dec.mem_w_en;
                        bus.wb_en    <= dec.wb_en;
                        bus.b        <= dec.b;
                        bus.s_out    <= dec.s_out;
                    end else if (bus.valid_i && in_any) begin
                        // First transfer goes out on the accept edge at offset 0.
                        bus.valid_o  <= 1'b1;
                        bus.exe_cmd  <= EXE_ADD;
                        bus.mem_r_en <= bus.s;
                        bus.mem_w_en <= ~bus.s;
                        bus.wb_en    <= bus.s;
                        bus.xfer_reg <= in_idx;
                        xfer_load    <= bus.s;
                        if (|in_rest) begin
                            state <= XFER;
                            mask  <= in_rest;
                            count <= IDX_W'(1);
                        end else begin
                            bus.last_o <= 1'b1;
                        end
                    end
                end
                XFER: begin
                    if (rem_any) begin
                        bus.valid_o  <= 1'b1;
                        bus.exe_cmd  <= EXE_ADD;
                        bus.mem_r_en <= xfer_load;
                        bus.mem_w_en <= ~xfer_load;
                        bus.wb_en    <= xfer_load;
                        bus.xfer_reg <= rem_idx;
                        bus.xfer_ofs <= OFS_W'({count, 2'b00});
                        mask         <= rem_rest;
                        if (count != IDX_W'(NREG - 1))
                            count <= count + IDX_W'(1);
                        if (rem_rest == '0) begin
                            bus.last_o <= 1'b1;
                            state      <= IDLE;
                            count      <= '0;
                        end
                    end else begin
                        state <= IDLE;
                        count <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_seq_unit.sv
// tb/tb_ctrl_seq_unit.sv - scoreboard bench for ctrl_seq_unit
module tb_ctrl_seq_unit;

    typedef logic [21:0] vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    vec_t exp_q[$];

    always #5 clk = ~clk;

    ctrl_seq_unit_if #(.NREG(16)) bus ();

    ctrl_seq_unit #(.NREG(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic vec_t mk(input logic [3:0] e, input logic r, input logic w, input logic wb,
                                input logic br, input logic so, input logic [3:0] rg,
                                input logic [5:0] ofs, input logic last, input logic busy);
        return {1'b1, e, r, w, wb, br, so, rg, ofs, last, busy};
    endfunction

    function automatic vec_t obs();
        return {bus.valid_o, bus.exe_cmd, bus.mem_r_en, bus.mem_w_en, bus.wb_en, bus.b,
                bus.s_out, bus.xfer_reg, bus.xfer_ofs, bus.last_o, bus.busy_o};
    endfunction

    task automatic check(input string name, input vec_t act, input vec_t req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drv(input logic v, input logic [1:0] md, input logic [3:0] op, input logic sb,
                       input logic ml, input logic [15:0] lst, input logic stl, input logic fl);
        @(negedge clk);
        bus.valid_i    = v;
        bus.mode       = md;
        bus.op_code    = op;
        bus.s          = sb;
        bus.multi_i    = ml;
        bus.reg_list_i = lst;
        bus.stall_i    = stl;
        bus.flush_i    = fl;
    endtask

    task automatic idle();
        drv(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic expect_bubble(input string name);
        @(posedge clk);
        #1;
        check(name, obs(), '0);
    endtask

    // Monitor: every issued micro-op is matched against the head of the scoreboard.
    always @(posedge clk) begin
        #1;
        if (bus.valid_o === 1'b1) begin
            if (exp_q.size() == 0)
                check("spurious_issue", obs(), '0);
            else
                check("issue", obs(), exp_q.pop_front());
        end
    end

    initial begin
        bus.valid_i = 0; bus.stall_i = 0; bus.flush_i = 0; bus.mode = 0;
        bus.op_code = 0; bus.s = 0; bus.multi_i = 0; bus.reg_list_i = 0;
        #1 rst = 1'b0;
        #3 check("reset_state", obs(), '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        drv(1, 2'b00, 4'b0100, 1, 0, 16'h0, 0, 0); exp_q.push_back(mk(4'b0010, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        drv(1, 2'b00, 4'b1010, 0, 0, 16'h0, 0, 0); exp_q.push_back(mk(4'b0100, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        drv(1, 2'b10, 4'b0100, 1, 0, 16'h0, 0, 0); exp_q.push_back(mk(4'b0000, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        drv(1, 2'b00, 4'b1111, 0, 0, 16'h0, 0, 0); exp_q.push_back(mk(4'b1001, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        drv(1, 2'b01, 4'b0100, 1, 0, 16'h0, 0, 0); exp_q.push_back(mk(4'b0010, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        drv(1, 2'b01, 4'b0100, 0, 0, 16'h0, 0, 0); exp_q.push_back(mk(4'b0010, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        drv(1, 2'b00, 4'b0011, 1, 0, 16'h0, 0, 0); exp_q.push_back(mk(4'b0000, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        drv(1, 2'b00, 4'b1000, 0, 0, 16'h0, 0, 0); exp_q.push_back(mk(4'b0110, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        idle(); expect_bubble("idle_bubble");

        drv(1, 2'b01, 4'b0100, 1, 1, 16'h8011, 0, 0);
        exp_q.push_back(mk(4'b0010, 1, 0, 1, 0, 0, 4'd0, 6'd0, 0, 1));
        exp_q.push_back(mk(4'b0010, 1, 0, 1, 0, 0, 4'd4, 6'd4, 0, 1));
        exp_q.push_back(mk(4'b0010, 1, 0, 1, 0, 0, 4'd15, 6'd8, 1, 0));
        idle(); idle();
        idle(); expect_bubble("ldm_done_bubble");

        drv(1, 2'b01, 4'b0100, 0, 1, 16'h0006, 0, 0);
        exp_q.push_back(mk(4'b0010, 0, 1, 0, 0, 0, 4'd1, 6'd0, 0, 1));
        drv(0, 2'b00, 4'b0000, 0, 0, 16'h0, 1, 0);
        exp_q.push_back(mk(4'b0010, 0, 1, 0, 0, 0, 4'd1, 6'd0, 0, 1));
        idle();
        exp_q.push_back(mk(4'b0010, 0, 1, 0, 0, 0, 4'd2, 6'd4, 1, 0));
        idle(); expect_bubble("stm_done_bubble");

        drv(1, 2'b01, 4'b0100, 1, 1, 16'h0000, 0, 0); expect_bubble("empty_list");

        drv(1, 2'b01, 4'b0100, 1, 1, 16'h00F0, 0, 0);
        exp_q.push_back(mk(4'b0010, 1, 0, 1, 0, 0, 4'd4, 6'd0, 0, 1));
        drv(0, 2'b00, 4'b0000, 0, 0, 16'h0, 0, 1); expect_bubble("flush_mid_xfer");
        idle(); expect_bubble("after_flush_1");
        idle(); expect_bubble("after_flush_2");

        drv(1, 2'b01, 4'b0100, 1, 1, 16'h00F0, 0, 0);
        exp_q.push_back(mk(4'b0010, 1, 0, 1, 0, 0, 4'd4, 6'd0, 0, 1));
        drv(0, 2'b00, 4'b0000, 0, 0, 16'h0, 1, 1); expect_bubble("flush_and_stall");
        idle(); expect_bubble("after_flush_stall");

        drv(1, 2'b00, 4'b0100, 1, 0, 16'h0, 0, 1); expect_bubble("flush_on_accept");

        drv(1, 2'b01, 4'b0100, 1, 1, 16'h00F0, 0, 0);
        exp_q.push_back(mk(4'b0010, 1, 0, 1, 0, 0, 4'd4, 6'd0, 0, 1));
        idle();
        #2 rst = 1'b0;
        #1 check("async_reset_mid_xfer", obs(), '0);
        @(negedge clk);
        rst = 1'b1;
        bus.valid_i = 1; bus.mode = 2'b00; bus.op_code = 4'b0100; bus.s = 1;
        exp_q.push_back(mk(4'b0010, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        idle(); idle(); idle();
        @(posedge clk); #2;

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drained actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctrl_seq_unit.md
# ctrl_seq_unit

Registered, parametrised successor to the single-cycle decode control unit. It sits between the IF/ID register and the EXE stage. It decodes mode/op_code/S into the EXE command and the memory, write-back and branch controls. It also sequences block transfers (LDM/STM style) into one memory micro-op per cycle, with stall, flush and a busy back-pressure to fetch.

## Interface
Parameters:
- NREG, 16, number of architectural registers; width of the register list.
- IDX_W, $clog2(NREG), width of the transfer register index.
- OFS_W, $clog2(NREG)+2, width of the byte offset of a transfer (index count × 4).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- valid_i  in  1  instruction at ID is valid.
- stall_i  in  1  hazard hold; freezes all state and outputs.
- flush_i  in  1  branch taken; kills the current and pending ops.
- mode  in  2  instruction class: 00 data-processing, 01 memory, 10 branch.
- op_code  in  4  data-processing opcode.
- s  in  1  S bit (set flags); in mode 01 this is the L bit (1 = load).
- multi_i  in  1  block transfer (valid only with mode 01).
- reg_list_i  in  NREG  block-transfer register mask.
- valid_o  out  1  issued micro-op valid.
- exe_cmd  out  4  ALU command.
- mem_r_en, mem_w_en, wb_en, b, s_out  out  1 each  stage controls.
- xfer_reg  out  IDX_W  register index of the current transfer.
- xfer_ofs  out  OFS_W  byte offset of the current transfer from base.
- last_o  out  1  final micro-op of a block transfer.
- busy_o  out  1  sequencer mid-transfer; fetch must hold ID.

## Operation
- States: IDLE and XFER, held in a state register.
- Decode table for mode 00/01; each opcode maps to exe_cmd:
  - MOV 1101 → 0001
  - MVN 1111 → 1001
  - ADD 0100 → 0010
  - ADC 0101 → 0011
  - SUB 0010 → 0100
  - SBC 0110 → 0101
  - AND 0000 → 0110
  - ORR 1100 → 0111
  - EOR 0001 → 1000
  - CMP 1010 → 0100
  - TST 1000 → 0110
  - all other opcodes, and mode 10/11 → 0000.
- Control outputs:
  - s_out: 0 in mode 01/10; 1 for CMP/TST; otherwise s.
  - mem_r_en = (mode 01) & s.
  - mem_w_en = (mode 01) & ~s.
  - b = (mode 10).
  - wb_en = 0 for mode 10, for mode 01 with s=0, and for CMP/TST in mode 00; otherwise 1.
- Single ops (multi_i=0, or mode ≠ 01):
  - Accepted in IDLE when valid_i=1 and stall_i=0.
  - Registered outputs load the decode; xfer_reg=0, xfer_ofs=0, last_o=0.
- Block ops (mode 01, multi_i=1):
  - exe_cmd is 0010; s_out is 0.
  - On accept, the first micro-op issues immediately for the lowest set bit of reg_list_i. The remaining mask keeps the other bits.
  - If the remaining mask is nonzero, go to XFER; otherwise set last_o=1 and stay in IDLE.
  - In XFER, each non-stalled cycle issues the lowest set bit of the remaining mask, clears that bit, and increments the count. xfer_ofs = count×4.
  - When the mask empties, issue with last_o=1 and return to IDLE.
  - An empty reg_list_i issues a bubble (valid_o=0).
- busy_o is 1 exactly while state=XFER. valid_i is ignored in XFER; upstream holds the instruction.
- When valid_i=0 in IDLE, the next cycle outputs a bubble: all enables 0, exe_cmd 0000, valid_o 0.
- Priority: reset > flush_i > stall_i > normal.
  - Flush: next edge outputs a bubble, state goes to IDLE, and the remaining mask and count are cleared.
  - Stall: all registers hold.
- Reset values: every output is 0; state IDLE; mask 0; count 0.

## Timing
- All outputs are registered. Latency from an accepted ID input to the outputs is 1 cycle.
- A block op with N set bits occupies N consecutive non-stalled output cycles. busy_o is high for cycles 1..N-1 after accept.
- Reset is asynchronous: outputs go to 0 without waiting for a clock edge, including mid-XFER. The first accept is possible on the first edge after rst deasserts.
- Flush and stall in the same cycle: flush wins.
- A flush in the accept cycle drops the incoming op.
- The count saturates logically at NREG-1; xfer_ofs never wraps for a legal list.

## Structure
- Shared package ctrl_pkg:
  - mode constants: MODE_DP, MODE_MEM, MODE_BR.
  - opcode constants.
  - EXE_* command constants.
  - state enum: IDLE, XFER.
- Sub-module lowest_set_enc (parametrised NREG): outputs the index of the lowest set bit and an any-set flag. It is instantiated twice, once on reg_list_i and once on the remaining mask.

## Test plan
- Single ops:
  - ADD (mode 00, op 0100, s=1, valid) → next cycle exe_cmd=0010, wb_en=1, s_out=1, valid_o=1.
  - CMP (op 1010, s=0) → exe_cmd=0100, wb_en=0, s_out=1.
  - Branch (mode 10) → b=1, wb_en=0, exe_cmd=0000.
- LDM with reg_list=16'h8011, s=1 → three cycles:
  - xfer_reg 0/4/15, xfer_ofs 0/4/8.
  - mem_r_en=1 and wb_en=1 each cycle.
  - busy_o 1,1,0; last_o only on the third cycle.
- STM with reg_list=16'h0006, stall_i=1 on the second cycle → outputs hold reg 1. Reg 2 (ofs 4, mem_w_en=1, last_o=1) issues after the stall releases.
- flush_i mid-XFER (list 16'h00F0, after the first issue) → next cycle bubble, busy_o=0, remaining regs never issued. flush_i+stall_i together → bubble.
- rst low mid-XFER → all outputs 0 asynchronously. After release, a valid ADD issues normally one cycle later.
